rof_sequencer: RTL and testbench
================================

# rof_sequencer

Sequencing controller for the masked rank-order filter datapath: it replaces free-running, gated-clock operation with a single-clock start/busy/done handshake. It streams NUM_SAMPLES ROM addresses into the filter, qualifies the filter pipeline with clock enables, and generates latency-matched write addresses and strobes for the result RAM. It supports a stall input so the display/readback logic can freeze the stream.

## Interface
- N, 81, filter window size (informational; forwarded to latency check only)
- DATA_BITS, 8, sample width (informational)
- ADDR_BITS, 8, ROM/RAM address width
- NUM_SAMPLES, 255, samples per run; must satisfy 1 <= NUM_SAMPLES <= 2**ADDR_BITS
- ROM_LATENCY, 1, cycles from rom_en+rom_addr to valid ROM data
- FILTER_LATENCY, 1, cycles from filt_en with valid input to valid filter output
- clk  in  1  single system clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled only in IDLE
- hold  in  1  stall; while high, all enables and counters freeze
- rom_addr  out  ADDR_BITS  ROM read address
- rom_en  out  1  ROM clock enable
- filt_en  out  1  filter clock enable
- ram_wr_addr  out  ADDR_BITS  result RAM write address
- ram_we  out  1  result RAM write strobe
- busy  out  1  run in progress (READ or DRAIN)
- done  out  1  one-cycle completion pulse

## Operation
- Reset (rst low): state IDLE; rom_addr=0, ram_wr_addr=0, valid pipeline cleared; rom_en, filt_en, ram_we, busy, done all 0. Reset mid-run aborts immediately; no further ram_we.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: outputs inactive. start=1 -> READ, rom_addr=0. start while busy/DONE ignored.
- READ: when hold=0, rom_en=1 and issue address rom_addr, inject 1 into valid pipeline, increment rom_addr. After issuing NUM_SAMPLES-1 -> DRAIN, rom_addr holds last value (no wrap).
- DRAIN: rom_en=0; shift 0s into pipeline while hold=0 until pipeline is empty -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. hold ignored in DONE.
- Valid pipeline: L = ROM_LATENCY + FILTER_LATENCY stages, advances only when hold=0. filt_en = (hold=0) and (any stage 0..ROM_LATENCY-1 occupied, i.e. valid data at filter input, or filter stages occupied). ram_we = (hold=0) and last stage valid.
- ram_wr_addr: starts at 0, increments after every ram_we; sample k is written at address k, k = 0..NUM_SAMPLES-1.
- hold=1: rom_en=filt_en=ram_we=0; all counters, pipeline and state frozen; release resumes with no lost or duplicated samples.
- busy=1 exactly in READ and DRAIN.

## Timing
- start high on cycle c in IDLE: cycle c+1 READ with rom_addr=0, rom_en=1, busy=1.
- Without hold: address k issued at c+1+k; ram_we for sample k at c+1+k+L; last ram_we at c+NUM_SAMPLES+L; done at next cycle; IDLE after that.
- Total start-to-done with no stalls: NUM_SAMPLES+L+1 cycles. Each hold cycle adds exactly one cycle.
- start and hold both high in IDLE: start accepted; first stall applies in READ.
- All outputs are registered or decoded from registered state and hold only; no combinational path from start to outputs.

## Structure
- Shared package rof_pkg: state enum (IDLE, READ, DRAIN, DONE), ROF_ADDR_BITS default, and a function computing L from the latency parameters.
- One sub-module: rof_valid_pipe, an L-deep shift register with enable and async active-low clear; exposes per-stage valid bits.
- Elaboration check: error if NUM_SAMPLES is out of range or if ROM_LATENCY or FILTER_LATENCY is 0.

## Test plan
- Reset/idle: rst low then high, no start -> all outputs 0 for 20 cycles; start pulse -> next cycle busy=1, rom_en=1, rom_addr=0.
- Full run, NUM_SAMPLES=255, L=2: exactly 255 ram_we pulses, addresses 0..254 in order, first at start+3, done once at start+258, busy low afterward.
- Stall: hold high for 5 cycles at rom_addr=100, then 3 cycles during DRAIN -> no enables during hold, done delayed by exactly 8 cycles, write sequence unchanged.
- Start ignored: start pulsed at cycles 10 and 200 of a run -> single run only, one done pulse.
- Reset mid-run: rst low at rom_addr=50 -> next edge outputs 0, state IDLE; new start restarts at rom_addr=0, ram_wr_addr=0.
- Edge size: NUM_SAMPLES=1, L=3 -> one ram_we at address 0 on start+4; done on start+5.

Source files
------------

// File: rtl/rof_pkg.sv
// Shared types and helpers for the rank-order-filter sequencer.
// The pipeline depth is the ROM read latency plus the filter latency.
package rof_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rof_state_e;

  localparam int ROF_ADDR_BITS = 8;

  function automatic int rof_pipe_len(input int rom_latency, input int filter_latency);
    return rom_latency + filter_latency;
  endfunction

endpackage

// File: rtl/rof_valid_pipe.sv
// Valid-bit shift register tracking samples in flight through ROM and filter.
// Bit 0 is the newest entry and bit DEPTH-1 marks data at the filter output.
module rof_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [DEPTH-1:0] valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (en) begin
      valid <= {valid[DEPTH-2:0], din};
    end
  end

endmodule

// File: rtl/rof_sequencer.sv
// Start/busy/done sequencer that streams ROM addresses through the filter and
// produces latency-matched result-RAM writes, with a hold input to freeze the stream.
module rof_sequencer
  import rof_pkg::*;
#(
  parameter int N              = 81,
  parameter int DATA_BITS      = 8,
  parameter int ADDR_BITS      = ROF_ADDR_BITS,
  parameter int NUM_SAMPLES    = 255,
  parameter int ROM_LATENCY    = 1,
  parameter int FILTER_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 rom_en,
  output logic                 filt_en,
  output logic [ADDR_BITS-1:0] ram_wr_addr,
  output logic                 ram_we,
  output logic                 busy,
  output logic                 done,
  output rof_state_e           state
);

  localparam int L = rof_pipe_len(ROM_LATENCY, FILTER_LATENCY);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_SAMPLES - 1);

  if (NUM_SAMPLES < 1 || NUM_SAMPLES > (2 ** ADDR_BITS)) begin : g_bad_num_samples
    $error("rof_sequencer: NUM_SAMPLES out of range");
  end
  if (ROM_LATENCY < 1 || FILTER_LATENCY < 1) begin : g_bad_latency
    $error("rof_sequencer: ROM_LATENCY and FILTER_LATENCY must be non-zero");
  end
  if (N < 1 || DATA_BITS < 1) begin : g_bad_window
    $error("rof_sequencer: N and DATA_BITS must be positive");
  end

  rof_state_e     state_q, state_d;
  logic [L-1:0]   valid;
  logic           inject;
  logic           drain_last;

  // Handshake: start is sampled only in IDLE; every enable and counter
  // advances only in cycles where hold is low, except DONE which ignores hold.
  rof_valid_pipe #(
    .DEPTH(L)
  ) u_valid_pipe (
    .clk  (clk),
    .rst  (rst),
    .en   (!hold),
    .din  (inject),
    .valid(valid)
  );

  // The pipe is empty after this shift once only the output stage remains.
  assign drain_last = (valid[L-2:0] == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    inject  = 1'b0;
    rom_en  = 1'b0;
    filt_en = 1'b0;
    ram_we  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = READ;
      end
      READ: begin
        busy    = 1'b1;
        inject  = 1'b1;
        rom_en  = !hold;
        filt_en = !hold && (valid != '0);
        ram_we  = !hold && valid[L-1];
        if (!hold && rom_addr == LAST_ADDR) state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        filt_en = !hold && (valid != '0);
        ram_we  = !hold && valid[L-1];
        if (!hold && drain_last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr    <= '0;
      ram_wr_addr <= '0;
    end else if (state_q == IDLE && start) begin
      rom_addr    <= '0;
      ram_wr_addr <= '0;
    end else begin
      if (rom_en && rom_addr != LAST_ADDR) rom_addr <= rom_addr + ADDR_BITS'(1);
      if (ram_we) ram_wr_addr <= ram_wr_addr + ADDR_BITS'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_rof_sequencer.sv
// Bench for rof_sequencer: two instances (255 samples/L=2 and 1 sample/L=3)
// checked cycle by cycle against a model counting active cycles since start.
module tb_rof_sequencer;
  import rof_pkg::*;

  localparam int AB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic sel = 1'b0;
  logic start1, start2;

  logic [AB-1:0] rom_addr1, ram_wr_addr1, rom_addr2, ram_wr_addr2;
  logic rom_en1, filt_en1, ram_we1, busy1, done1;
  logic rom_en2, filt_en2, ram_we2, busy2, done2;
  rof_state_e state1, state2;

  logic [AB-1:0] o_rom_addr, o_ram_wr_addr;
  logic [4:0]    o_ctl;
  rof_state_e    o_state;

  int checks = 0;
  int errors = 0;
  logic [AB-1:0] exp_q[$];

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start2 = start & sel;

  rof_sequencer #(
    .NUM_SAMPLES(255), .ROM_LATENCY(1), .FILTER_LATENCY(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start1), .hold(hold),
    .rom_addr(rom_addr1), .rom_en(rom_en1), .filt_en(filt_en1),
    .ram_wr_addr(ram_wr_addr1), .ram_we(ram_we1), .busy(busy1),
    .done(done1), .state(state1)
  );

  rof_sequencer #(
    .NUM_SAMPLES(1), .ROM_LATENCY(2), .FILTER_LATENCY(1)
  ) dut_small (
    .clk(clk), .rst(rst), .start(start2), .hold(hold),
    .rom_addr(rom_addr2), .rom_en(rom_en2), .filt_en(filt_en2),
    .ram_wr_addr(ram_wr_addr2), .ram_we(ram_we2), .busy(busy2),
    .done(done2), .state(state2)
  );

  always_comb begin
    if (sel) begin
      o_ctl         = {rom_en2, filt_en2, ram_we2, busy2, done2};
      o_rom_addr    = rom_addr2;
      o_ram_wr_addr = ram_wr_addr2;
      o_state       = state2;
    end else begin
      o_ctl         = {rom_en1, filt_en1, ram_we1, busy1, done1};
      o_rom_addr    = rom_addr1;
      o_ram_wr_addr = ram_wr_addr1;
      o_state       = state1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, int'(o_ctl), 0);
    check({tag, "_state"}, int'(o_state), int'(IDLE));
  endtask

  // mode: 0 no hold, 1 random hold, 2 directed stalls, 3 stray starts, 4 reset at address 50
  task automatic run_one(input int ns, input int l, input int mode);
    int a;
    int holds;
    int exp_addr;
    bit h;
    bit finished;
    logic [4:0] exp_ctl;
    logic [AB-1:0] wa;
    exp_q.delete();
    for (int k = 0; k < ns; k++) exp_q.push_back(AB'(k));
    @(posedge clk); #1;
    start = 1'b1;
    hold  = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_quiet("pre_start");
    a = 0;
    holds = 0;
    finished = 1'b0;
    for (int j = 1; j < 3000 && !finished; j++) begin
      @(posedge clk); #1;
      start = (mode == 3 && (j == 10 || j == 200));
      case (mode)
        1:       h = ($urandom_range(0, 7) == 0);
        2:       h = (a == 100 && holds < 5) || (a == ns + 1 && holds >= 5 && holds < 8);
        default: h = 1'b0;
      endcase
      hold = h;
      @(negedge clk);
      if (a == ns + l) begin
        check("done_ctl", int'(o_ctl), 5'b00001);
        check("done_state", int'(o_state), int'(DONE));
        finished = 1'b1;
      end else begin
        exp_ctl[0] = 1'b0;
        exp_ctl[1] = 1'b1;
        exp_ctl[4] = !h && (a < ns);
        exp_ctl[3] = !h && (a >= 1) && (a <= ns + l - 1);
        exp_ctl[2] = !h && (a >= l);
        exp_addr = (a < ns) ? a : ns - 1;
        check("ctl", int'(o_ctl), int'(exp_ctl));
        check("rom_addr", int'(o_rom_addr), exp_addr);
        if (o_ctl[2]) begin
          if (exp_q.size() == 0) begin
            check("ram_we_extra", 1, 0);
          end else begin
            wa = exp_q.pop_front();
            check("ram_wr_addr", int'(o_ram_wr_addr), int'(wa));
          end
        end
        if (mode == 4 && !h && a == 50) begin
          rst = 1'b0;
          #1;
          check_quiet("abort");
          check("abort_addrs", int'({o_rom_addr, o_ram_wr_addr}), 0);
          @(posedge clk); #1;
          rst = 1'b1;
          hold = 1'b0;
          start = 1'b0;
          return;
        end
        if (h) holds++;
        else a++;
      end
    end
    start = 1'b0;
    hold  = 1'b0;
    if (!finished) check("timeout_no_done", 0, 1);
    check("writes_left", exp_q.size(), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_quiet("idle_after");
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      sel = 1'b0; #1;
      check_quiet("reset_idle1");
      sel = 1'b1; #1;
      check_quiet("reset_idle2");
      sel = 1'b0;
    end

    sel = 1'b0;
    run_one(255, 2, 0);
    run_one(255, 2, 2);
    run_one(255, 2, 3);
    run_one(255, 2, 4);
    run_one(255, 2, 0);
    for (int k = 0; k < 3; k++) run_one(255, 2, 1);

    @(posedge clk); #1;
    sel = 1'b1;
    run_one(1, 3, 0);
    for (int k = 0; k < 6; k++) run_one(1, 3, 1);
    run_one(1, 3, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
